// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
// Forwarding-select generator and stall sequencer for a 5-stage MIPS pipeline.
// A shadow copy of {valid, dest, reg_write, mem_read} is kept for the EX, MEM
// and WB stages. From it the block:
//   - computes the registered EX operand mux selects
//     (0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB writeback value),
//   - detects load-use hazards and inserts a one-cycle bubble into EX,
//   - holds EX for multi-cycle operations with a RUN / MC_BUSY down-counter FSM.
//
// Handshake semantics: there is no valid/ready pair here. stall_id=1 means the
// current ID instruction is not consumed this cycle and must be presented
// again unchanged next cycle. ex_hold=1 means ID/EX keeps its contents and a
// bubble goes into EX/MEM.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               ID source registers
//   id_rs_used, id_rt_used     the instruction reads rs / rt
//   id_dest                    destination register
//   id_reg_write               the instruction writes the register file
//   id_mem_read                the instruction is a load
//   id_multicycle              the instruction is a multi-cycle EX operation
//   stall_id                   combinational: hold PC and IF/ID
//   ex_hold                    registered: hold ID/EX, bubble into EX/MEM
//   fwd_a_sel, fwd_b_sel       registered operand mux selects
//   ex_start                   registered: first cycle of a valid EX occupant
//   dbg_state, dbg_cnt, dbg_wb debug view of the FSM state, counter and WB shadow
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_multicycle,
  output logic                  stall_id,
  output logic                  ex_hold,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  ex_start,
  output logic                  dbg_state,
  output logic [3:0]            dbg_cnt,
  output logic [REG_ADDR_W+2:0] dbg_wb
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } shadow_t;

  // Counter value on entry: the entry cycle itself is the first of the
  // MC_LATENCY cycles, so MC_BUSY lasts MC_LATENCY-1 cycles.
  localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  shadow_t    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       ex_hold_q, ex_hold_d;
  logic       ex_start_q, ex_start_d;

  shadow_t    id_shadow;
  logic       rs_ex, rs_mem, rt_ex, rt_mem;
  logic       load_use;
  logic [1:0] sel_a_new, sel_b_new;

  function automatic logic src_match(input logic used,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input shadow_t st);
    // $0 is hard-wired to zero and is never forwarded.
    return used && (src != '0) && st.valid && st.reg_write && (st.dest == src);
  endfunction

  assign id_shadow = '{valid: id_valid, dest: id_dest,
                       reg_write: id_reg_write, mem_read: id_mem_read};

  assign rs_ex  = src_match(id_rs_used, id_rs, ex_q);
  assign rs_mem = src_match(id_rs_used, id_rs, mem_q);
  assign rt_ex  = src_match(id_rt_used, id_rt, ex_q);
  assign rt_mem = src_match(id_rt_used, id_rt, mem_q);

  // The newest producer (EX) takes precedence over the older one (MEM).
  assign sel_a_new = rs_ex ? 2'd1 : (rs_mem ? 2'd2 : 2'd0);
  assign sel_b_new = rt_ex ? 2'd1 : (rt_mem ? 2'd2 : 2'd0);

  assign load_use = (state_q == ST_RUN) && id_valid && ex_q.valid &&
                    ex_q.mem_read && (rs_ex || rt_ex);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = wb_q;
    fwd_a_d    = fwd_a_q;
    fwd_b_d    = fwd_b_q;
    ex_start_d = 1'b0;
    stall_id   = 1'b0;
    case (state_q)
      ST_RUN: begin
        mem_d = ex_q;
        wb_d  = mem_q;
        if (load_use) begin
          // Bubble into EX; the consumer retries next cycle, when the load
          // has moved to MEM and its data comes from MEM/WB.
          stall_id = 1'b1;
          ex_d     = '0;
          fwd_a_d  = 2'd0;
          fwd_b_d  = 2'd0;
        end else begin
          ex_d       = id_shadow;
          fwd_a_d    = sel_a_new;
          fwd_b_d    = sel_b_new;
          ex_start_d = id_valid;
          if (id_valid && id_multicycle) begin
            cnt_d   = MC_LOAD;
            state_d = ST_MC_BUSY;
          end
        end
      end
      ST_MC_BUSY: begin
        // EX shadow and selects hold; the operation's result is not in
        // EX/MEM yet, so bubbles drain into MEM behind it.
        stall_id = 1'b1;
        mem_d    = '0;
        wb_d     = mem_q;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    ex_hold_d = (state_d == ST_MC_BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      fwd_a_q    <= 2'd0;
      fwd_b_q    <= 2'd0;
      ex_hold_q  <= 1'b0;
      ex_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      ex_hold_q  <= ex_hold_d;
      ex_start_q <= ex_start_d;
    end
  end

  assign ex_hold   = ex_hold_q;
  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign ex_start  = ex_start_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;
  assign dbg_wb    = wb_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Testbench for fwd_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a stage-list reference model.
module tb_fwd_hazard_ctrl;

  localparam int W   = 5;
  localparam int LAT = 4;

  logic         clk;
  logic         rst_n;
  logic         id_valid;
  logic [W-1:0] id_rs, id_rt, id_dest;
  logic         id_rs_used, id_rt_used, id_reg_write, id_mem_read, id_multicycle;
  logic         stall_id, ex_hold, ex_start;
  logic [1:0]   fwd_a_sel, fwd_b_sel;
  logic         dbg_state;
  logic [3:0]   dbg_cnt;
  logic [W+2:0] dbg_wb;

  // Observed bundle: {stall_id, ex_hold, fwd_a_sel, fwd_b_sel, ex_start}
  logic [6:0] obs;
  assign obs = {stall_id, ex_hold, fwd_a_sel, fwd_b_sel, ex_start};

  int n_vec;
  int n_err;

  fwd_hazard_ctrl #(.REG_ADDR_W(W), .MC_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_multicycle(id_multicycle), .stall_id(stall_id), .ex_hold(ex_hold),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_start(ex_start),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt), .dbg_wb(dbg_wb)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int rs, input bit rsu, input int rt,
                       input bit rtu, input int dest, input bit rw,
                       input bit mr, input bit mc);
    id_valid      = v;
    id_rs         = W'(rs);
    id_rs_used    = rsu;
    id_rt         = W'(rt);
    id_rt_used    = rtu;
    id_dest       = W'(dest);
    id_reg_write  = rw;
    id_mem_read   = mr;
    id_multicycle = mc;
    #1;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; returns 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    int dest;
    bit rw;
    bit mr;
  } instr_t;

  instr_t pipe[3];       // [0]=EX, [1]=MEM, [2]=WB
  int     busy_left;     // remaining cycles the EX occupant is held
  logic [6:0] exp_q[$];  // expected obs, one entry per cycle

  bit m_hold, m_start;
  int m_a, m_b;

  // Age-ordered producer search: 1 if the youngest writer is in EX,
  // 2 if in MEM, 0 if no in-flight writer (or $0 / unused source).
  function automatic int producer_code(input int s, input bit used);
    if (!used || s == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].dest == s) return k + 1;
    return 0;
  endfunction

  function automatic bit model_load_use(input bit v, input int rs, input bit rsu,
                                        input int rt, input bit rtu);
    if (busy_left > 0 || !v) return 0;
    if (!(pipe[0].v && pipe[0].mr)) return 0;
    return producer_code(rs, rsu) == 1 || producer_code(rt, rtu) == 1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{v: 0, dest: 0, rw: 0, mr: 0};
    busy_left = 0;
    m_hold = 0; m_start = 0; m_a = 0; m_b = 0;
  endfunction

  function automatic void model_edge(input bit v, input int rs, input bit rsu,
                                     input int rt, input bit rtu, input int dest,
                                     input bit rw, input bit mr, input bit mc);
    instr_t empty;
    empty = '{v: 0, dest: 0, rw: 0, mr: 0};
    if (busy_left > 0) begin
      pipe[2] = pipe[1];
      pipe[1] = empty;
      busy_left--;
      m_start = 0;
    end else if (model_load_use(v, rs, rsu, rt, rtu)) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = empty;
      m_a = 0; m_b = 0; m_start = 0;
    end else begin
      m_a = producer_code(rs, rsu);
      m_b = producer_code(rt, rtu);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{v: v, dest: dest, rw: rw, mr: mr};
      m_start = v;
      busy_left = (v && mc) ? LAT - 1 : 0;
    end
    m_hold = busy_left > 0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    #3;
    n_vec++;
    if (obs !== 7'b0) begin
      n_err++; $display("FAIL reset_active obs=%b exp=%b", obs, 7'b0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (obs !== 7'b0) begin
      n_err++; $display("FAIL reset_release obs=%b exp=%b", obs, 7'b0);
    end
  endtask

  task automatic test_forwarding();
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0);              // add $3
    tick();
    drive(1, 3, 1, 1, 1, 6, 1, 0, 0);              // sub rs=$3
    n_vec++;
    if (obs !== 7'b0_0_00_00_1) begin
      n_err++; $display("FAIL fwd_add_entry obs=%b exp=%b", obs, 7'b0_0_00_00_1);
    end
    tick();
    drive(1, 7, 1, 3, 1, 7, 1, 0, 0);              // or rt=$3
    n_vec++;
    if (obs !== 7'b0_0_01_00_1) begin
      n_err++; $display("FAIL fwd_exmem obs=%b exp=%b", obs, 7'b0_0_01_00_1);
    end
    tick();
    drive_idle();
    n_vec++;
    if (obs !== 7'b0_0_00_10_1) begin
      n_err++; $display("FAIL fwd_memwb obs=%b exp=%b", obs, 7'b0_0_00_10_1);
    end
    tick();
  endtask

  task automatic test_newest_wins();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 9, 1, 0, 0);              // and rs=$5
    tick();
    drive_idle();
    n_vec++;
    if (obs !== 7'b0_0_01_00_1) begin
      n_err++; $display("FAIL newest_wins obs=%b exp=%b", obs, 7'b0_0_01_00_1);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);              // writes $0
    tick();
    drive(1, 0, 1, 0, 1, 2, 1, 0, 0);              // reads $0 twice
    tick();
    drive_idle();
    n_vec++;
    if (obs !== 7'b0_0_00_00_1) begin
      n_err++; $display("FAIL no_fwd_r0 obs=%b exp=%b", obs, 7'b0_0_00_00_1);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(1, 1, 1, 0, 0, 4, 1, 1, 0);              // lw $4
    tick();
    drive(1, 4, 1, 2, 1, 9, 1, 0, 0);              // add rs=$4
    n_vec++;
    if (obs !== 7'b1_0_00_00_1) begin
      n_err++; $display("FAIL lu_stall obs=%b exp=%b", obs, 7'b1_0_00_00_1);
    end
    tick();
    n_vec++;
    if (obs !== 7'b0_0_00_00_0) begin
      n_err++; $display("FAIL lu_bubble obs=%b exp=%b", obs, 7'b0_0_00_00_0);
    end
    tick();
    drive_idle();
    n_vec++;
    if (obs !== 7'b0_0_10_00_1) begin
      n_err++; $display("FAIL lu_consumer obs=%b exp=%b", obs, 7'b0_0_10_00_1);
    end
    tick();
  endtask

  task automatic test_multicycle();
    logic [6:0] exp_c [4];
    exp_c[0] = 7'b1_1_00_00_1;
    exp_c[1] = 7'b1_1_00_00_0;
    exp_c[2] = 7'b1_1_00_00_0;
    exp_c[3] = 7'b0_0_00_00_0;
    drive(1, 1, 1, 2, 1, 8, 1, 0, 1);              // mult $8
    tick();
    drive(1, 8, 1, 0, 0, 10, 1, 0, 0);             // addu rs=$8
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (obs !== exp_c[c]) begin
        n_err++; $display("FAIL mc_cycle%0d obs=%b exp=%b", c, obs, exp_c[c]);
      end
      tick();
    end
    drive_idle();
    n_vec++;
    if (obs !== 7'b0_0_01_00_1) begin
      n_err++; $display("FAIL mc_consumer obs=%b exp=%b", obs, 7'b0_0_01_00_1);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);              // add $9
    tick();
    drive(1, 9, 1, 0, 0, 11, 1, 0, 1);             // mult rs=$9
    tick();
    drive(1, 11, 1, 0, 0, 12, 1, 0, 0);
    tick();
    n_vec++;
    if (obs !== 7'b1_1_01_00_0) begin
      n_err++; $display("FAIL mid_busy obs=%b exp=%b", obs, 7'b1_1_01_00_0);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== 7'b0) begin
      n_err++; $display("FAIL mid_reset obs=%b exp=%b", obs, 7'b0);
    end
    tick();
    rst_n = 1'b1;
    drive(1, 12, 1, 13, 1, 14, 1, 0, 0);
    n_vec++;
    if (obs !== 7'b0) begin
      n_err++; $display("FAIL post_reset_nostall obs=%b exp=%b", obs, 7'b0);
    end
    tick();
    drive_idle();
    n_vec++;
    if (obs !== 7'b0_0_00_00_1) begin
      n_err++; $display("FAIL post_reset_flow obs=%b exp=%b", obs, 7'b0_0_00_00_1);
    end
    tick();
  endtask

  task automatic test_random();
    bit v, rsu, rtu, rw, mr, mc, stall_exp;
    int rs, rt, dest;
    logic [6:0] exp_v;
    apply_reset();
    model_reset();
    stall_exp = 0;
    v = 0; rs = 0; rt = 0; rsu = 0; rtu = 0; dest = 0; rw = 0; mr = 0; mc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // A stalled ID instruction is presented again unchanged.
      if (!stall_exp) begin
        v    = $urandom_range(0, 9) < 8;
        rs   = $urandom_range(0, 3);
        rt   = $urandom_range(0, 3);
        rsu  = $urandom_range(0, 9) < 7;
        rtu  = $urandom_range(0, 9) < 7;
        dest = $urandom_range(0, 3);
        rw   = $urandom_range(0, 9) < 8;
        mr   = $urandom_range(0, 9) < 3;
        mc   = $urandom_range(0, 9) < 1;
      end
      drive(v, rs, rsu, rt, rtu, dest, rw, mr, mc);
      stall_exp = (busy_left > 0) || model_load_use(v, rs, rsu, rt, rtu);
      exp_q.push_back({stall_exp, m_hold, 2'(m_a), 2'(m_b), m_start});
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL rand_cyc%0d obs=%b exp=%b", cyc, obs, exp_v);
      end
      model_edge(v, rs, rsu, rt, rtu, dest, rw, mr, mc);
      tick();
    end
    drive_idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_forwarding();
    test_newest_wins();
    test_load_use();
    test_multicycle();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
